// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Snapshots DIGITS active-low seven-segment patterns and scans them one
//   digit at a time, LSB digit first. Each digit is decoded to a hex nibble
//   and flagged invalid if it is not a legal 0-F glyph.
//
// Parameters
//   DIGITS    number of digits scanned (1..8)
//   SCAN_DIV  clock cycles spent per digit (>=1)
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     scan request, accepted when not busy (IDLE or DONE)
//   hex_in    digit k on [7k+6:7k], bit0 = seg a .. bit6 = seg g, 0 = lit
//   busy      scan in progress
//   done      one-cycle pulse at scan completion
//   value     decoded nibble for digit k on [4k+3:4k]
//   digit_ok  bit k set when digit k matched a legal pattern
//   err       some digit of the last scan was invalid (sticky until next accept)
//
// Build option
//   SEG7_BLANK_EN  when defined, the all-off pattern decodes as a legal blank
module seg7_scan_decoder #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7*DIGITS-1:0]   hex_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  err
);

  localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t              state, state_nx;
  logic [7*DIGITS-1:0] snap;
  logic [IW-1:0]       idx;
  logic [DW-1:0]       div;
  logic                fin;
  logic                accept;
  logic [6:0]          cur_pat;
  logic [4:0]          cur_dec;

  // Returns {legal, nibble}; patterns are g..a with 0 = segment lit.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    r = '0;
    case (p)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
`ifdef SEG7_BLANK_EN
      7'b1111111: r = {1'b1, 4'h0};
`endif
      default:    r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    accept   = start && (state != SCAN);
    cur_pat  = snap[idx*7 +: 7];
    cur_dec  = seg_decode(cur_pat);
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      // fin is raised by the final digit write, so SCAN lingers one extra
      // cycle after the last slot before DONE.
      SCAN:    if (fin) state_nx = DONE;
      DONE:    state_nx = start ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap     <= '0;
      idx      <= '0;
      div      <= '0;
      fin      <= 1'b0;
      value    <= '0;
      digit_ok <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      snap     <= hex_in;
      idx      <= '0;
      div      <= '0;
      fin      <= 1'b0;
      value    <= '0;
      digit_ok <= '0;
      err      <= 1'b0;
    end else if (state == SCAN && !fin) begin
      if (div == DIV_MAX) begin
        div                <= '0;
        value[idx*4 +: 4]  <= cur_dec[3:0];
        digit_ok[idx]      <= cur_dec[4];
        if (!cur_dec[4]) err <= 1'b1;
        // Index stops at the last digit rather than wrapping; fin marks the end.
        if (idx == LAST_IDX) fin <= 1'b1;
        else                 idx <= idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  ok;
    logic        e;
  } exp_t;

  // Legal glyphs 0..F as g..a, 0 = lit.
  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk;
  logic        reset_n;
  logic        start, start3;
  logic [27:0] hex_in, hex_in3;
  logic        busy, busy3, done, done3, err, err3;
  logic [15:0] value, value3;
  logic [3:0]  digit_ok, digit_ok3;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t ex;

  seg7_scan_decoder #(.DIGITS(4), .SCAN_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .hex_in(hex_in),
    .busy(busy), .done(done), .value(value), .digit_ok(digit_ok), .err(err)
  );

  seg7_scan_decoder #(.DIGITS(4), .SCAN_DIV(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .hex_in(hex_in3),
    .busy(busy3), .done(done3), .value(value3), .digit_ok(digit_ok3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [27:0] h);
    exp_t r;
    r.v = '0; r.ok = '0; r.e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [6:0] p;
      p = h[k*7 +: 7];
      for (int j = 0; j < 16; j++)
        if (p == PAT[j]) begin
          r.v[k*4 +: 4] = 4'(j);
          r.ok[k] = 1'b1;
        end
`ifdef SEG7_BLANK_EN
      if (p == 7'b1111111) r.ok[k] = 1'b1;
`endif
      if (!r.ok[k]) r.e = 1'b1;
    end
    return r;
  endfunction

  // Drive a start pulse on the SCAN_DIV=1 instance and record the expectation.
  task automatic launch(input logic [27:0] h);
    @(negedge clk);
    hex_in = h;
    start  = 1'b1;
    sbq.push_back(model(h));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // From the accept edge, count edges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    reset_n = 1'b0; start = 1'b0; start3 = 1'b0; hex_in = '0; hex_in3 = '0;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, value, digit_ok, err} !== 23'd0) begin bad++;
      $display("FAIL reset_outs got=%h want=0", {busy, done, value, digit_ok, err}); end
    total++; if ({busy3, done3, value3, digit_ok3, err3} !== 23'd0) begin bad++;
      $display("FAIL reset_outs3 got=%h want=0", {busy3, done3, value3, digit_ok3, err3}); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++;
      $display("FAIL idle_after_reset got=%b want=00", {busy, done}); end
    n = 0;
  endtask

  task automatic test_basic;
    int n;
    @(negedge clk);
    hex_in = {PAT[3], PAT[2], PAT[1], PAT[0]};
    start  = 1'b1;
    sbq.push_back(model(hex_in));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b10) begin bad++;
      $display("FAIL basic_busy got=%b want=10", {busy, done}); end
    @(negedge clk);
    total++; if (digit_ok !== 4'b0001) begin bad++;
      $display("FAIL basic_digit0 got=%b want=0001", digit_ok); end
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 5) begin bad++;
      $display("FAIL basic_latency got=%0d want=5", n); end
    ex = sbq.pop_front();
    total++; if ({value, digit_ok, err} !== {ex.v, ex.ok, ex.e}) begin bad++;
      $display("FAIL basic_result got=%h/%b/%b want=%h/%b/%b", value, digit_ok, err, ex.v, ex.ok, ex.e); end
    total++; if (value !== 16'h3210 || busy !== 1'b0) begin bad++;
      $display("FAIL basic_value got=%h busy=%b want=3210 busy=0", value, busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++;
      $display("FAIL basic_done_width got=%b want=0", done); end
  endtask

  task automatic test_all_patterns;
    int n;
    for (int s = 0; s < 4; s++) begin
      launch({PAT[4*s+3], PAT[4*s+2], PAT[4*s+1], PAT[4*s]});
      wait_done(n);
      total++; if (n !== 5) begin bad++;
        $display("FAIL pat%0d_latency got=%0d want=5", s, n); end
      ex = sbq.pop_front();
      total++; if ({value, digit_ok, err} !== {ex.v, ex.ok, ex.e} || err !== 1'b0) begin bad++;
        $display("FAIL pat%0d_result got=%h/%b/%b want=%h/%b/%b", s, value, digit_ok, err, ex.v, ex.ok, ex.e); end
    end
  endtask

  task automatic test_blank;
    int n;
    launch({PAT[3], 7'b1111111, PAT[1], PAT[0]});
    wait_done(n);
    ex = sbq.pop_front();
    total++; if ({value, digit_ok, err} !== {ex.v, ex.ok, ex.e}) begin bad++;
      $display("FAIL blank_result got=%h/%b/%b want=%h/%b/%b", value, digit_ok, err, ex.v, ex.ok, ex.e); end
`ifdef SEG7_BLANK_EN
    total++; if ({value, digit_ok, err} !== {16'h3010, 4'hF, 1'b0}) begin bad++;
      $display("FAIL blank_fixed got=%h/%b/%b want=3010/1111/0", value, digit_ok, err); end
`else
    total++; if ({value, digit_ok, err} !== {16'h3010, 4'b1011, 1'b1}) begin bad++;
      $display("FAIL blank_fixed got=%h/%b/%b want=3010/1011/1", value, digit_ok, err); end
`endif
  endtask

  task automatic test_div3;
    int dcount, dcyc;
    logic [27:0] h;
    h = {PAT[13], PAT[12], PAT[11], PAT[10]};
    @(negedge clk);
    hex_in3 = h;
    start3  = 1'b1;
    sbq.push_back(model(h));
    @(posedge clk);
    #1 start3 = 1'b0;
    dcount = 0; dcyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 2 || n == 7) begin
        start3  = 1'b1;
        hex_in3 = {PAT[0], PAT[0], PAT[0], 7'b0101010};
      end else begin
        start3 = 1'b0;
      end
      @(negedge clk);
      if (done3) begin
        dcount++;
        if (dcyc < 0) dcyc = n;
      end
      if (n == 2) begin
        total++; if (digit_ok3 !== 4'b0000 || busy3 !== 1'b1) begin bad++;
          $display("FAIL div3_slot_early got=%b busy=%b want=0000 busy=1", digit_ok3, busy3); end
      end
      if (n == 3) begin
        total++; if (digit_ok3 !== 4'b0001 || value3 !== 16'h000A) begin bad++;
          $display("FAIL div3_slot0 got=%b/%h want=0001/000a", digit_ok3, value3); end
      end
    end
    total++; if (dcount !== 1 || dcyc !== 13) begin bad++;
      $display("FAIL div3_done got=%0d pulses at %0d want=1 at 13", dcount, dcyc); end
    ex = sbq.pop_front();
    total++; if ({value3, digit_ok3, err3} !== {ex.v, ex.ok, ex.e} || value3 !== 16'hDCBA) begin bad++;
      $display("FAIL div3_result got=%h/%b/%b want=%h/%b/%b", value3, digit_ok3, err3, ex.v, ex.ok, ex.e); end
  endtask

  task automatic test_back_to_back;
    logic [27:0] hs [3];
    int n;
    hs[0] = {PAT[1], PAT[2], 7'b1010101, PAT[4]};
    hs[1] = {PAT[5], PAT[6], PAT[7], PAT[8]};
    hs[2] = {PAT[9], PAT[15], PAT[14], PAT[0]};
    @(negedge clk);
    hex_in = hs[0];
    start  = 1'b1;
    sbq.push_back(model(hs[0]));
    @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total++; if ({busy, done, err, digit_ok} !== 7'b1000000) begin bad++;
        $display("FAIL b2b%0d_accept got=%b want=1000000", s, {busy, done, err, digit_ok}); end
      n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      total++; if (n !== 5) begin bad++;
        $display("FAIL b2b%0d_latency got=%0d want=5", s, n); end
      ex = sbq.pop_front();
      total++; if ({value, digit_ok, err} !== {ex.v, ex.ok, ex.e}) begin bad++;
        $display("FAIL b2b%0d_result got=%h/%b/%b want=%h/%b/%b", s, value, digit_ok, err, ex.v, ex.ok, ex.e); end
      if (s < 2) begin
        hex_in = hs[s+1];
        sbq.push_back(model(hs[s+1]));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++;
      $display("FAIL b2b_idle got=%b want=00", {busy, done}); end
  endtask

  task automatic test_reset_mid;
    int n, dseen;
    launch({PAT[7], PAT[6], PAT[5], PAT[4]});
    repeat (3) @(negedge clk);
    total++; if (digit_ok !== 4'b0011) begin bad++;
      $display("FAIL mid_partial got=%b want=0011", digit_ok); end
    reset_n = 1'b0;
    #1;
    sbq.delete();
    total++; if ({busy, done, value, digit_ok, err} !== 23'd0) begin bad++;
      $display("FAIL mid_reset_outs got=%h want=0", {busy, done, value, digit_ok, err}); end
    @(negedge clk);
    reset_n = 1'b1;
    dseen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    total++; if (dseen !== 0) begin bad++;
      $display("FAIL mid_no_done got=%0d active cycles want=0", dseen); end
    launch({PAT[15], PAT[0], PAT[10], PAT[1]});
    wait_done(n);
    total++; if (n !== 5) begin bad++;
      $display("FAIL mid_rerun_latency got=%0d want=5", n); end
    ex = sbq.pop_front();
    total++; if ({value, digit_ok, err} !== {ex.v, ex.ok, ex.e} || value !== 16'hF0A1) begin bad++;
      $display("FAIL mid_rerun_result got=%h/%b/%b want=%h/%b/%b", value, digit_ok, err, ex.v, ex.ok, ex.e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_all_patterns();
    test_blank();
    test_div3();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
